// File: rtl/vector_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vector_arbiter
// Description : Round-robin arbiter that lets NB_REQ requesters share one
//               8-bit vector buffer. Each grant issues one buffer request,
//               samples the response, then either delivers the vector or
//               retries, dropping the request after MAX_RETRY empty replies.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_arbiter #(
   parameter int NB_REQ    = 4,
   parameter int MAX_RETRY = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NB_REQ-1:0] req,
   output logic              buf_req,
   input  logic [7:0]        buf_vector,
   input  logic              buf_valid,
   output logic [NB_REQ-1:0] grant,
   output logic [7:0]        vector,
   output logic              valid,
   output logic              drop,
   output logic              busy
);

   localparam int c_SEL_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
   localparam int c_CNT_W = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_DELIVER = 2'd3
   } state_t;

   state_t              r_state;
   logic [c_SEL_W-1:0]  r_rr_ptr;
   logic [c_SEL_W-1:0]  r_sel;
   logic [c_CNT_W-1:0]  r_retry_cnt;
   logic                r_buf_req;
   logic [NB_REQ-1:0]   r_grant;
   logic [7:0]          r_vector;
   logic                r_valid;
   logic                r_drop;
   logic                r_busy;

   logic [c_SEL_W-1:0]  w_pick;
   logic                w_found;
   logic [NB_REQ-1:0]   w_onehot;
   logic [c_SEL_W-1:0]  w_ptr_after_sel;
   logic [c_CNT_W-1:0]  w_retry_inc;
   logic                w_retry_exhausted;

   // Find the first active request at or after the round-robin pointer, wrapping
   always_comb begin : arb_scan
      int v;
      w_pick  = r_rr_ptr;
      w_found = 1'b0;
      v       = 0;
      for (int i = 0; i < NB_REQ; i++) begin
         v = int'(r_rr_ptr) + i;
         if (v >= NB_REQ) begin
            v = v - NB_REQ;
         end
         if (!w_found && req[v]) begin
            w_found = 1'b1;
            w_pick  = c_SEL_W'(v);
         end
      end
   end

   // One-hot form of the winning requester, loaded into grant on arbitration
   always_comb begin
      w_onehot         = '0;
      w_onehot[w_pick] = 1'b1;
   end

   // Pointer moves past the current owner once its transaction finishes or is dropped
   always_comb begin
      w_ptr_after_sel   = (r_sel == c_SEL_W'(NB_REQ - 1)) ? '0 : r_sel + 1'b1;
      w_retry_inc       = r_retry_cnt + 1'b1;
      w_retry_exhausted = (w_retry_inc >= c_CNT_W'(MAX_RETRY));
   end

   // Transaction sequencer: arbitration, buffer handshake, retry bookkeeping, outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_sel       <= '0;
         r_retry_cnt <= '0;
         r_buf_req   <= 1'b0;
         r_grant     <= '0;
         r_vector    <= 8'h00;
         r_valid     <= 1'b0;
         r_drop      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // Single-cycle outputs default low and are raised only where needed
         r_buf_req <= 1'b0;
         r_valid   <= 1'b0;
         r_vector  <= 8'h00;
         r_drop    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  // A new owner starts its own retry budget
                  if (w_pick != r_sel) begin
                     r_retry_cnt <= '0;
                  end
                  r_sel     <= w_pick;
                  r_grant   <= w_onehot;
                  r_buf_req <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (buf_valid) begin
                  r_vector    <= buf_vector;
                  r_valid     <= 1'b1;
                  r_rr_ptr    <= w_ptr_after_sel;
                  r_retry_cnt <= '0;
                  r_state     <= S_DELIVER;
               end else begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                  if (w_retry_exhausted) begin
                     r_drop      <= 1'b1;
                     r_retry_cnt <= '0;
                     r_rr_ptr    <= w_ptr_after_sel;
                  end else begin
                     // Pointer held so the same requester wins again if still asking
                     r_retry_cnt <= w_retry_inc;
                  end
               end
            end
            S_DELIVER: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_grant <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign buf_req = r_buf_req;
   assign grant   = r_grant;
   assign vector  = r_vector;
   assign valid   = r_valid;
   assign drop    = r_drop;
   assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vector_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_arbiter
// Description : Self-checking bench for vector_arbiter. A transaction-level
//               model predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_arbiter;

   localparam int NB        = 4;
   localparam int MAX_RETRY = 3;

   logic          clk;
   logic          rst_n;
   logic [NB-1:0] req;
   logic          buf_req;
   logic [7:0]    buf_vector;
   logic          buf_valid;
   logic [NB-1:0] grant;
   logic [7:0]    vector;
   logic          valid;
   logic          drop;
   logic          busy;

   int checks = 0;
   int errors = 0;

   vector_arbiter #(
      .NB_REQ    (NB),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .buf_req    (buf_req),
      .buf_vector (buf_vector),
      .buf_valid  (buf_valid),
      .grant      (grant),
      .vector     (vector),
      .valid      (valid),
      .drop       (drop),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // m_age counts edges since the arbitration edge of the current transaction
   int            m_age, m_ptr, m_sel, m_retry;
   logic          e_buf_req, e_valid, e_drop, e_busy;
   logic [NB-1:0] e_grant;
   logic [7:0]    e_vector;

   task automatic model_step();
      int  nsel;
      bit  found;
      e_buf_req = 1'b0; e_valid = 1'b0; e_drop = 1'b0; e_busy = 1'b0;
      e_grant   = '0;   e_vector = 8'h00;
      if (!rst_n) begin
         m_age = 0; m_ptr = 0; m_sel = 0; m_retry = 0;
         return;
      end
      case (m_age)
         0: begin
            found = 1'b0;
            nsel  = 0;
            for (int k = 0; k < NB; k++) begin
               if (!found && req[(m_ptr + k) % NB]) begin
                  found = 1'b1;
                  nsel  = (m_ptr + k) % NB;
               end
            end
            if (found) begin
               if (nsel != m_sel) m_retry = 0;
               m_sel     = nsel;
               m_age     = 1;
               e_buf_req = 1'b1;
               e_busy    = 1'b1;
               e_grant[m_sel] = 1'b1;
            end
         end
         1: begin
            m_age  = 2;
            e_busy = 1'b1;
            e_grant[m_sel] = 1'b1;
         end
         2: begin
            if (buf_valid) begin
               m_age    = 3;
               e_valid  = 1'b1;
               e_vector = buf_vector;
               e_busy   = 1'b1;
               e_grant[m_sel] = 1'b1;
               m_ptr    = (m_sel + 1) % NB;
               m_retry  = 0;
            end else begin
               m_age = 0;
               if (m_retry + 1 < MAX_RETRY) begin
                  m_retry = m_retry + 1;
               end else begin
                  e_drop  = 1'b1;
                  m_retry = 0;
                  m_ptr   = (m_sel + 1) % NB;
               end
            end
         end
         default: m_age = 0;
      endcase
   endtask

   initial begin
      m_age = 0; m_ptr = 0; m_sel = 0; m_retry = 0;
      e_buf_req = 1'b0; e_valid = 1'b0; e_drop = 1'b0; e_busy = 1'b0;
      e_grant = '0; e_vector = 8'h00;
      forever begin
         @(posedge clk or negedge rst_n);
         model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         check("m_buf_req", 32'(buf_req), 32'(e_buf_req));
         check("m_grant",   32'(grant),   32'(e_grant));
         check("m_vector",  32'(vector),  32'(e_vector));
         check("m_valid",   32'(valid),   32'(e_valid));
         check("m_drop",    32'(drop),    32'(e_drop));
         check("m_busy",    32'(busy),    32'(e_busy));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [NB-1:0] g_exp;

   initial begin
      rst_n      = 1'b0;
      req        = '0;
      buf_valid  = 1'b0;
      buf_vector = 8'h00;

      // Reset state
      tick();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_busy",  32'(busy),  32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      rst_n = 1'b1;

      // Single requester, buffer returns A5
      do_reset();
      req = 4'b0001; buf_valid = 1'b1; buf_vector = 8'hA5;
      tick();
      check("a_buf_req", 32'(buf_req), 32'h1);
      check("a_grant1",  32'(grant),   32'h1);
      req = '0;
      tick();
      check("a_wait_breq", 32'(buf_req), 32'h0);
      tick();
      check("a_valid",  32'(valid),  32'h1);
      check("a_vector", 32'(vector), 32'hA5);
      check("a_grant3", 32'(grant),  32'h1);
      tick();
      check("a_idle_valid", 32'(valid), 32'h0);

      // All requesting, rotating grants every 4 cycles
      do_reset();
      req = 4'b1111; buf_valid = 1'b1; buf_vector = 8'h11;
      g_exp = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         repeat ((i == 0) ? 1 : 4) tick();
         check("b_rr_grant", 32'(grant), 32'(g_exp));
         g_exp = {g_exp[NB-2:0], g_exp[NB-1]};
      end
      req = '0;
      repeat (3) tick();

      // Always-empty buffer: three rounds then drop, pointer past requester 2
      do_reset();
      req = 4'b0100; buf_valid = 1'b0;
      tick();
      check("c_breq_r1", 32'(buf_req), 32'h1);
      check("c_grant",   32'(grant),   32'h4);
      tick();
      tick();
      check("c_nodrop", 32'(drop), 32'h0);
      tick();
      check("c_breq_r2", 32'(buf_req), 32'h1);
      repeat (3) tick();
      check("c_breq_r3", 32'(buf_req), 32'h1);
      tick();
      tick();
      check("c_drop",    32'(drop),  32'h1);
      check("c_novalid", 32'(valid), 32'h0);
      req = 4'b1100;
      tick();
      check("c_ptr3_grant", 32'(grant), 32'h8);
      check("c_drop_end",   32'(drop),  32'h0);
      req = '0;
      repeat (3) tick();

      // Wrap-around: pointer at 2, requests 0 and 1 -> requester 0
      do_reset();
      req = 4'b0010; buf_valid = 1'b1; buf_vector = 8'h3C;
      tick();
      req = '0;
      repeat (3) tick();
      req = 4'b0011;
      tick();
      check("d_wrap_grant", 32'(grant), 32'h1);
      req = '0;
      repeat (3) tick();

      // Requester 1 drops its request during WAIT; delivery still completes
      do_reset();
      req = 4'b0010; buf_valid = 1'b1; buf_vector = 8'h5A;
      tick();
      tick();
      req = '0;
      tick();
      check("e_valid",  32'(valid),  32'h1);
      check("e_grant",  32'(grant),  32'h2);
      check("e_vector", 32'(vector), 32'h5A);
      tick();

      // Reset pulse during WAIT aborts the transaction immediately
      do_reset();
      req = 4'b0001; buf_valid = 1'b1; buf_vector = 8'h77;
      tick();
      tick();
      #2 rst_n = 1'b0;
      req = '0;
      #1;
      check("f_grant",   32'(grant),   32'h0);
      check("f_busy",    32'(busy),    32'h0);
      check("f_valid",   32'(valid),   32'h0);
      check("f_buf_req", 32'(buf_req), 32'h0);
      tick();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         check("f_no_valid", 32'(valid), 32'h0);
      end

      // Random traffic with occasional resets
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         tick();
         if ($urandom_range(0, 3) == 0) req = NB'($urandom);
         buf_valid  = ($urandom_range(0, 99) < 60);
         buf_vector = 8'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
      end
      req = '0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vector_arbiter.md
VECTOR_ARBITER -- requirements
Module: vector_arbiter

Interface
REQ-001 The block SHALL have parameter NB_REQ, default 4: number of requesters sharing one vector buffer (range 2..8).
REQ-002 The block SHALL have parameter MAX_RETRY, default 15: consecutive empty responses before a request is dropped (range 1..255).
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port req, input, NB_REQ: per-requester level request for one 8-bit vector.
REQ-006 The block SHALL have port buf_req, output, 1: request pulse to the vector buffer.
REQ-007 The block SHALL have port buf_vector, input, 8: vector returned by the buffer.
REQ-008 The block SHALL have port buf_valid, input, 1: buffer response valid; 0 means the buffer was empty.
REQ-009 The block SHALL have port grant, output, NB_REQ: one-hot owner of the current transaction.
REQ-010 The block SHALL have port vector, output, 8: delivered vector.
REQ-011 The block SHALL have port valid, output, 1: vector is delivered to the granted requester this cycle.
REQ-012 The block SHALL have port drop, output, 1: one-cycle pulse when a request is abandoned after MAX_RETRY empties.
REQ-013 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, ISSUE, WAIT and DELIVER; all outputs SHALL be registered.
REQ-015 In IDLE with req != 0, the block SHALL select the first set req bit at or after rr_ptr, scanning upward with wrap-around, latch it as sel and go to ISSUE; with req == 0 it SHALL stay in IDLE.
REQ-016 ISSUE SHALL last exactly one cycle with buf_req=1, then go to WAIT; buf_req SHALL be 0 in all other states.
REQ-017 grant SHALL equal onehot(sel) in ISSUE, WAIT and DELIVER, and 0 in IDLE.
REQ-018 WAIT SHALL last exactly one cycle; at its closing edge the block SHALL sample buf_valid and buf_vector.
REQ-019 If buf_valid=1 in WAIT: the block SHALL register vector=buf_vector, set rr_ptr=(sel+1) mod NB_REQ, clear retry_cnt and go to DELIVER.
REQ-020 DELIVER SHALL last one cycle with valid=1, then go to IDLE; valid SHALL be 0 and vector SHALL be 8'h00 in every other state.
REQ-021 If buf_valid=0 in WAIT and retry_cnt+1 < MAX_RETRY: the block SHALL increment retry_cnt, leave rr_ptr unchanged and return to IDLE, so the same requester is retried if still requesting.
REQ-022 If buf_valid=0 in WAIT and retry_cnt+1 == MAX_RETRY: the block SHALL pulse drop for one cycle (the first IDLE cycle), clear retry_cnt, set rr_ptr=(sel+1) mod NB_REQ and return to IDLE.
REQ-023 retry_cnt SHALL be ceil(log2(MAX_RETRY+1)) bits and SHALL also clear whenever a grant goes to a requester other than the previous sel.
REQ-024 Latency: with the buffer non-empty, the block SHALL assert valid 3 cycles after the edge that samples req in IDLE (ISSUE, WAIT, DELIVER); back-to-back transactions SHALL occur every 4 cycles.
REQ-025 When the granted requester deasserts req mid-transaction, the block SHALL still complete the transaction and SHALL still deliver the vector under its grant.
REQ-026 req changes outside IDLE SHALL NOT affect sel or grant.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force state=IDLE, rr_ptr=0, sel=0, retry_cnt=0, buf_req=0, grant=0, vector=8'h00, valid=0, drop=0 and busy=0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no valid or drop pulse; the first arbitration after release SHALL start from rr_ptr=0.

Verification
REQ-029 The bench SHALL cover: req=4'b0001 with the buffer returning 8'hA5 -> buf_req one cycle later, valid=1, vector=8'hA5, grant=4'b0001 three cycles after the sampling edge.
REQ-030 The bench SHALL cover: req=4'b1111 held with the buffer always valid -> grants 0001, 0010, 0100, 1000, 0001 at a 4-cycle spacing.
REQ-031 The bench SHALL cover: req=4'b0100 with an always-empty buffer and MAX_RETRY=3 -> three ISSUE/WAIT rounds, then one drop pulse, no valid, rr_ptr=3.
REQ-032 The bench SHALL cover: rr_ptr=2 with req=4'b0011 -> requester 0 granted (wrap-around).
REQ-033 The bench SHALL cover: requester 1 deasserts req during WAIT -> valid and grant=4'b0010 still asserted in DELIVER.
REQ-034 The bench SHALL cover: rst_n pulsed low during WAIT -> all outputs 0 immediately, with no valid afterwards until a new request.
